// File: rtl/player_input_conditioner.sv
// Synchronises and debounces player buttons; one strobe plus a latched one-hot code per accepted press, strobe DEBOUNCE_CYCLES+2 edges after first sample.
// No backpressure: presses while disabled or multi-button presses raise invalid_press, and nothing new is taken until a debounced release.
module player_input_conditioner #(
  parameter int DATA_WIDTH      = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] buttons_raw,
  input  logic                  enable,
  output logic [DATA_WIDTH-1:0] player_input,
  output logic                  button_player_pressed,
  output logic                  invalid_press,
  output logic                  busy
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    ACCEPT,
    RELEASE_WAIT
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] meta_q;
  logic [DATA_WIDTH-1:0] sync_q;
  logic [DATA_WIDTH-1:0] cand_q, cand_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] pi_q, pi_d;
  logic                  pressed_q, pressed_d;
  logic                  invalid_q, invalid_d;
  logic                  cand_onehot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= buttons_raw;
      sync_q <= meta_q;
    end
  end

  assign cand_onehot = $onehot(cand_q);

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    pi_d      = pi_q;
    pressed_d = 1'b0;
    invalid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync_q != '0) begin
          cand_d  = sync_q;
          cnt_d   = '0;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        // Any change of level, including a different button mix, restarts the stable window.
        if (sync_q == '0) begin
          state_d = IDLE;
        end else if (sync_q != cand_q) begin
          cand_d = sync_q;
          cnt_d  = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end else if (cand_onehot && enable) begin
          pressed_d = 1'b1;
          pi_d      = cand_q;
          state_d   = ACCEPT;
        end else begin
          invalid_d = 1'b1;
          cnt_d     = '0;
          state_d   = RELEASE_WAIT;
        end
      end
      ACCEPT: begin
        cnt_d   = '0;
        state_d = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (sync_q != '0) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = RELEASE_WAIT;
      end
    endcase
  end

  // Reset lands in RELEASE_WAIT so a button held through reset must be released first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RELEASE_WAIT;
      cand_q    <= '0;
      cnt_q     <= '0;
      pi_q      <= '0;
      pressed_q <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      pi_q      <= pi_d;
      pressed_q <= pressed_d;
      invalid_q <= invalid_d;
    end
  end

  assign player_input          = pi_q;
  assign button_player_pressed = pressed_q;
  assign invalid_press         = invalid_q;
  assign busy                  = (state_q != IDLE);

  assert property (@(posedge clk) disable iff (!rst_n) !(button_player_pressed && invalid_press));
  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(player_input));

endmodule

// File: doc/player_input_conditioner.md
Name: player_input_conditioner

Overview:
Conditions the raw player buttons for the game controller. It synchronises and debounces the buttons, then accepts exactly one press at a time. For each accepted press it presents a latched one-hot colour code on player_input and a single-cycle button_player_pressed strobe. It sits directly upstream of the controller FSM, which consumes both outputs in its GET_PLAYER_INPUT/COMPARISON states.

Parameters:
DATA_WIDTH, 4, number of buttons/colours; player_input is one-hot over this width.
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before a level is accepted; minimum 2; counter width $clog2(DEBOUNCE_CYCLES).

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
buttons_raw  input  DATA_WIDTH  raw asynchronous buttons, active-high
enable  input  1  controller accepts presses (driven from player_wr)
player_input  output  DATA_WIDTH  last accepted one-hot code, held until next accept
button_player_pressed  output  1  one-cycle strobe per accepted press
invalid_press  output  1  one-cycle strobe: stable multi-button press or press while disabled
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, rst_n=0):
  - sync FFs = 0, candidate = 0, counter = 0.
  - player_input = 0, button_player_pressed = 0, invalid_press = 0.
  - State = RELEASE_WAIT, so a button held through reset is never accepted.
- Synchroniser: 2-FF per bit; internal vector sync = second stage.
- States:
  - IDLE:
    - sync==0: stay.
    - sync!=0: candidate<=sync, cnt<=0, go DEBOUNCE.
  - DEBOUNCE:
    - sync==0: go IDLE (glitch rejected, no strobe).
    - sync!=0 and sync!=candidate: candidate<=sync, cnt<=0, stay.
    - sync==candidate and cnt<DEBOUNCE_CYCLES-1: cnt++.
    - sync==candidate and cnt==DEBOUNCE_CYCLES-1: decide.
  - Decide:
    - candidate one-hot and enable=1: go ACCEPT.
    - Otherwise: pulse invalid_press for 1 cycle, go RELEASE_WAIT.
    - enable is sampled only in the decide cycle.
  - ACCEPT (1 cycle):
    - button_player_pressed=1 and player_input<=candidate, both registered and updated on the same edge.
    - Then go RELEASE_WAIT with cnt<=0.
  - RELEASE_WAIT:
    - sync!=0: cnt<=0.
    - sync==0: cnt++.
    - cnt==DEBOUNCE_CYCLES-1 with sync==0: go IDLE.
- Latency:
  - Let E0 be the first edge at which raw is sampled high.
  - Strobe rises at edge E0+DEBOUNCE_CYCLES+2 and lasts exactly 1 cycle.
- One press yields at most one strobe, regardless of hold length.
- A new press is ignored until a full debounced release has completed.
- player_input is never cleared except by reset; invalid presses do not change it.
- button_player_pressed and invalid_press are mutually exclusive and never asserted in consecutive cycles.
- Bounce shorter than DEBOUNCE_CYCLES restarts the counter. Acceptance requires an uninterrupted stable window.
- Reset mid-operation: immediate async return to the reset values above; no strobe in flight survives.

Test Plan:
1. DEBOUNCE_CYCLES=4, enable=1: buttons_raw=4'b0010 held 20 cycles, then 0 → one strobe exactly 6 edges after the first sampling edge; player_input=4'b0010 held after release; no second strobe.
2. Bounce: raw 0100 toggles 0100/0000 every 2 cycles for 10 cycles, then stable 0100 → no strobe during bounce; exactly one strobe 6 edges after the stable level starts; player_input=0100.
3. Multi-press: raw=4'b0011 stable 10 cycles → invalid_press pulses once, no button_player_pressed, player_input unchanged (4'b0000 after reset).
4. Disabled: enable=0, raw=4'b1000 stable → invalid_press once. Then enable=1 while still held → no strobe until release plus a 4-cycle debounced release; a second press of 1000 is accepted.
5. Held through reset: raw=0001 high, pulse rst_n low 3 cycles mid-DEBOUNCE → outputs 0 immediately; no strobe while held; strobe only after release and re-press.
6. Back-to-back presses 0001, 0010, 0100, 1000, each 8 cycles with 8-cycle gaps → four strobes with player_input matching each code in order; busy low only in gaps after the release debounce.
